four_bit_down_counter: RTL and testbench



---
 rtl/four_bit_down_counter.sv | 100 ++++++++++
 tb/tb_four_bit_down_counter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/four_bit_down_counter.sv
// Loadable 4-bit countdown timer with start/busy/done handshake; expiry pulses done for one cycle.
// Optional periodic mode: define DOWN_COUNTER_AUTORELOAD_EN to reload from load on expiry instead of stopping.
module four_bit_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             count,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_dec;
  logic             w_carry;
  logic             w_load_zero;
  logic             w_out_one;

  // Decrement as out + all-ones through a ripple-carry chain; final carry-out is dropped.
  always_comb begin
    w_dec   = '0;
    w_carry = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_dec[i] = r_out[i] ^ 1'b1 ^ w_carry;
      w_carry  = r_out[i] | w_carry;
    end
  end

  assign w_load_zero = (load == '0);
  assign w_out_one   = (r_out == WIDTH'(1));

  // Single state/output register process; start takes priority in every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (start) begin
      r_out <= load;
      if (w_load_zero) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        r_state <= S_RUN;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (count) begin
            if (w_out_one) begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
              r_out  <= load;
              r_done <= 1'b1;
              if (w_load_zero) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
              end
`else
              r_out   <= '0;
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end else begin
              r_out <= w_dec;
            end
          end
        end
        default: begin
          // DONE falls back to IDLE; out is already zero here.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_four_bit_down_counter.sv
// Self-checking bench for four_bit_down_counter: directed scenarios then random traffic vs. an arithmetic model.
module tb_four_bit_down_counter;

  logic       clock;
  logic       reset;
  logic       start;
  logic       count;
  logic [3:0] load;
  logic [3:0] out;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference state: remaining interval as an integer and whether a countdown is in progress.
  int m_out     = 0;
  bit m_running = 1'b0;
  bit m_done    = 1'b0;

  four_bit_down_counter #(.WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .count (count),
    .load  (load),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the timer's rules, then compare.
  task automatic step(input bit rst, input bit st, input bit cnt, input int ld);
    reset = rst;
    start = st;
    count = cnt;
    load  = 4'(ld);
    @(posedge clock);
    cyc++;
    if (rst) begin
      m_out = 0; m_running = 1'b0; m_done = 1'b0;
    end else if (st) begin
      m_out     = ld;
      m_running = (ld != 0);
      m_done    = (ld == 0);
    end else if (m_running && cnt) begin
      m_out  = m_out - 1;
      m_done = 1'b0;
      if (m_out == 0) begin
        m_done = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        m_out     = ld;
        m_running = (ld != 0);
`else
        m_running = 1'b0;
`endif
      end
    end else begin
      m_done = 1'b0;
    end
    #1;
    if (m_out < 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL model_underflow cyc=%0d observed=%0d expected=>=0", cyc, m_out);
    end
    chk("out",  out,       4'(m_out));
    chk("busy", 4'(busy),  4'(m_running));
    chk("done", 4'(done),  4'(m_done));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; count = 1'b0; load = 4'd0;
    #2;

    // Reset held with start asserted
    step(1, 1, 0, 9);
    step(1, 1, 0, 9);
    step(0, 0, 0, 9);
    step(0, 0, 1, 9);

    // load=5 with count held high, then idle
    step(0, 1, 1, 5);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 12);

    // load=3 with count toggling
    step(0, 1, 1, 3);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // load=0 expires immediately
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Restart mid-count: 7 down to 4, then reload 2
    step(0, 1, 1, 7);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 7);
    step(0, 1, 1, 2);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 9);

    // Reset mid-count at out=3
    step(0, 1, 1, 6);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 6);
    step(1, 0, 1, 6);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 6);

    // load=4 with count high for a dozen cycles (periodic in the reload build)
    step(0, 1, 1, 4);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 4);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Random traffic; load wanders so late load changes are exercised
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0),
           (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15))));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
